key_schedule_ctrl: RTL and testbench



---
 rtl/key_schedule_ctrl.sv | 125 ++++++++++++
 tb/tb_key_schedule_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_ctrl.sv
// AES-128 key-schedule sequencer with an 11-entry round-key file and indexed read port.
// Build option KS_ZEROIZE_EN adds a ZEROIZE input that wipes all key material.
module key_schedule_ctrl #(
  parameter int unsigned EXP_LAT    = 1,
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
`ifdef KS_ZEROIZE_EN
  input  logic         ZEROIZE,
`endif
  input  logic [127:0] KEY_IN,
  input  logic         KEY_VALID,
  output logic         KEY_READY,
  output logic [3:0]   EXP_ROUND,
  output logic [127:0] EXP_KEY,
  input  logic [127:0] EXP_RESULT,
  output logic         KEYS_VALID,
  output logic         BUSY,
  input  logic [3:0]   RK_IDX,
  output logic [127:0] RK_OUT
);

  localparam logic [1:0] LAT  = 2'(EXP_LAT);
  localparam logic [3:0] LAST = 4'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [1:0]   lat_q, lat_d;
  logic [127:0] cur_q, cur_d;
  logic [127:0] rd_q, rd_d;
  logic [127:0] rk_q [11];
  logic         acc, cap, clr;

`ifdef KS_ZEROIZE_EN
  assign clr = ZEROIZE;
`else
  assign clr = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    lat_d   = lat_q;
    cur_d   = cur_q;
    acc     = 1'b0;
    cap     = 1'b0;
    rd_d    = '0;
    for (int i = 0; i < 11; i++) begin
      if (RK_IDX == 4'(i)) rd_d = rk_q[i];
    end
    if (clr) begin
      state_d = IDLE;
      rnd_d   = '0;
      lat_d   = '0;
      cur_d   = '0;
      rd_d    = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (lat_q == LAT) begin
            cap   = 1'b1;
            cur_d = EXP_RESULT;
            lat_d = '0;
            if (rnd_q == LAST) state_d = DONE;
            else rnd_d = rnd_q + 4'd1;
          end else begin
            lat_d = lat_q + 2'd1;
          end
        end
        IDLE, DONE: begin
          if (KEY_VALID) begin
            acc     = 1'b1;
            cur_d   = KEY_IN;
            rnd_d   = '0;
            lat_d   = '0;
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      lat_q   <= '0;
      cur_q   <= '0;
      rd_q    <= '0;
      for (int i = 0; i < 11; i++) rk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      lat_q   <= lat_d;
      cur_q   <= cur_d;
      rd_q    <= rd_d;
      if (clr) begin
        for (int i = 0; i < 11; i++) rk_q[i] <= '0;
      end else begin
        if (acc) rk_q[0] <= KEY_IN;
        if (cap) begin
          for (int i = 1; i < 11; i++) begin
            if (rnd_q + 4'd1 == 4'(i)) rk_q[i] <= EXP_RESULT;
          end
        end
      end
    end
  end

  assign KEY_READY  = (state_q != RUN);
  assign BUSY       = (state_q == RUN);
  assign KEYS_VALID = (state_q == DONE);
  assign EXP_ROUND  = rnd_q;
  assign EXP_KEY    = cur_q;
  assign RK_OUT     = rd_q;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Bench: three controllers (EXP_LAT 0/1/3) driving behavioural AES key-expansion units.
// Build option KS_ZEROIZE_EN adds the zeroize scenario.
module tb_key_schedule_ctrl;

  localparam logic [127:0] K1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_RA = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam int LATS [3] = '{10, 20, 40};
  localparam int WIN  [3] = '{1, 2, 4};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [127:0] KEY_IN = '0;
  logic         KEY_VALID = 1'b0;
  logic [3:0]   RK_IDX = '0;
`ifdef KS_ZEROIZE_EN
  logic         zeroize = 1'b0;
`endif

  logic [2:0]   rdy, bsy, kv;
  logic [3:0]   er [3];
  logic [127:0] ek [3];
  logic [127:0] rko [3];
  logic [127:0] res0, res1, p3a, p3b, res3;

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gm(r, a);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] k, input logic [3:0] rnd);
    logic [7:0]  rc;
    logic [31:0] w3, rot, t, w4, w5, w6, w7;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) if (i < int'(rnd)) rc = gm(rc, 8'h02);
    w3  = k[31:0];
    rot = {w3[23:0], w3[31:24]};
    t   = {sb(rot[31:24]), sb(rot[23:16]), sb(rot[15:8]), sb(rot[7:0])};
    t   = t ^ {rc, 24'h0};
    w4  = k[127:96] ^ t;
    w5  = k[95:64] ^ w4;
    w6  = k[63:32] ^ w5;
    w7  = k[31:0] ^ w6;
    return {w4, w5, w6, w7};
  endfunction

  assign res0 = expand(ek[0], er[0]);
  always @(posedge clk) begin
    res1 <= expand(ek[1], er[1]);
    p3a  <= expand(ek[2], er[2]);
    p3b  <= p3a;
    res3 <= p3b;
  end

  key_schedule_ctrl #(.EXP_LAT(0), .NUM_ROUNDS(10)) u0 (
    .clk(clk), .rst(rst),
`ifdef KS_ZEROIZE_EN
    .ZEROIZE(zeroize),
`endif
    .KEY_IN(KEY_IN), .KEY_VALID(KEY_VALID), .KEY_READY(rdy[0]),
    .EXP_ROUND(er[0]), .EXP_KEY(ek[0]), .EXP_RESULT(res0),
    .KEYS_VALID(kv[0]), .BUSY(bsy[0]), .RK_IDX(RK_IDX), .RK_OUT(rko[0])
  );

  key_schedule_ctrl #(.EXP_LAT(1), .NUM_ROUNDS(10)) u1 (
    .clk(clk), .rst(rst),
`ifdef KS_ZEROIZE_EN
    .ZEROIZE(zeroize),
`endif
    .KEY_IN(KEY_IN), .KEY_VALID(KEY_VALID), .KEY_READY(rdy[1]),
    .EXP_ROUND(er[1]), .EXP_KEY(ek[1]), .EXP_RESULT(res1),
    .KEYS_VALID(kv[1]), .BUSY(bsy[1]), .RK_IDX(RK_IDX), .RK_OUT(rko[1])
  );

  key_schedule_ctrl #(.EXP_LAT(3), .NUM_ROUNDS(10)) u3 (
    .clk(clk), .rst(rst),
`ifdef KS_ZEROIZE_EN
    .ZEROIZE(zeroize),
`endif
    .KEY_IN(KEY_IN), .KEY_VALID(KEY_VALID), .KEY_READY(rdy[2]),
    .EXP_ROUND(er[2]), .EXP_KEY(ek[2]), .EXP_RESULT(res3),
    .KEYS_VALID(kv[2]), .BUSY(bsy[2]), .RK_IDX(RK_IDX), .RK_OUT(rko[2])
  );

  logic [127:0] rd_exp [$];
  logic [2:0]   rd_msk [$];
  int           rd_tag [$];
  logic [2:0]   st_exp [$];
  int           st_tag [$];
  int           tmo_q  [$];
  int           lq [3][$];

  int checks = 0;
  int errors = 0;
  logic rd_req = 1'b0;
  logic rd_vld = 1'b0;
  logic fin = 1'b0;
  logic fin_done = 1'b0;

  int           cnt [3] = '{0, 0, 0};
  int           len [3] = '{1, 1, 1};
  logic [2:0]   kvp = '0;
  logic [2:0]   pbsy = '0;
  logic [3:0]   per [3] = '{4'd0, 4'd0, 4'd0};
  logic [127:0] pek [3] = '{128'd0, 128'd0, 128'd0};

  always @(posedge clk) rd_vld <= rd_req;

  always @(negedge clk) begin : mon
    int nc, ne, t;
    logic [127:0] e;
    logic [2:0] m, s;
    nc = 0;
    ne = 0;
    if (rd_vld && rd_exp.size() > 0) begin
      e = rd_exp.pop_front();
      m = rd_msk.pop_front();
      t = rd_tag.pop_front();
      for (int i = 0; i < 3; i++) begin
        if (m[i]) begin
          nc++;
          if (rko[i] !== e) begin
            ne++;
            $display("FAIL rd%0d u%0d RK_OUT got %h want %h", t, i, rko[i], e);
          end
        end
      end
    end
    if (st_exp.size() > 0) begin
      s = st_exp.pop_front();
      t = st_tag.pop_front();
      nc++;
      if ({rdy[1], bsy[1], kv[1]} !== s) begin
        ne++;
        $display("FAIL st%0d rdy/busy/kv got %b want %b", t, {rdy[1], bsy[1], kv[1]}, s);
      end
    end
    while (tmo_q.size() > 0) begin
      t = tmo_q.pop_front();
      nc++;
      ne++;
      $display("FAIL tmo%0d KEYS_VALID got %b want 111", t, kv);
    end
    for (int i = 0; i < 3; i++) begin
      cnt[i] <= (KEY_VALID && rdy[i]) ? 0 : cnt[i] + 1;
      kvp[i] <= kv[i];
      if (kv[i] && !kvp[i] && lq[i].size() > 0) begin
        t = lq[i].pop_front();
        nc++;
        if (cnt[i] != t) begin
          ne++;
          $display("FAIL kv_lat u%0d got %0d want %0d", i, cnt[i], t);
        end
      end
      per[i]  <= er[i];
      pek[i]  <= ek[i];
      pbsy[i] <= bsy[i];
      if (bsy[i] && pbsy[i]) begin
        nc++;
        if (er[i] == per[i]) begin
          if (ek[i] !== pek[i]) begin
            ne++;
            $display("FAIL ek_stable u%0d got %h want %h", i, ek[i], pek[i]);
          end
          len[i] <= len[i] + 1;
        end else begin
          if (len[i] != WIN[i]) begin
            ne++;
            $display("FAIL round_win u%0d got %0d want %0d", i, len[i], WIN[i]);
          end
          len[i] <= 1;
        end
      end else begin
        len[i] <= 1;
      end
    end
    if (fin && !fin_done) begin
      nc++;
      t = rd_exp.size() + st_exp.size() + lq[0].size() + lq[1].size() + lq[2].size();
      if (t != 0) begin
        ne++;
        $display("FAIL drain pending got %0d want 0", t);
      end
      fin_done <= 1'b1;
    end
    checks <= checks + nc;
    errors <= errors + ne;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [127:0] k);
    tick();
    KEY_IN = k;
    KEY_VALID = 1'b1;
    tick();
    KEY_VALID = 1'b0;
  endtask

  task automatic expect_lat();
    for (int i = 0; i < 3; i++) lq[i].push_back(LATS[i]);
  endtask

  task automatic rd(input logic [3:0] idx, input logic [127:0] e,
                    input logic [2:0] m, input int t);
    tick();
    RK_IDX = idx;
    rd_req = 1'b1;
    rd_exp.push_back(e);
    rd_msk.push_back(m);
    rd_tag.push_back(t);
  endtask

  task automatic rd_end();
    tick();
    rd_req = 1'b0;
  endtask

  task automatic st(input logic [2:0] e, input int t);
    st_exp.push_back(e);
    st_tag.push_back(t);
  endtask

  task automatic wait_kv(input int t);
    int n;
    n = 0;
    while (kv != 3'b111 && n < 100) begin
      tick();
      n++;
    end
    if (kv != 3'b111) tmo_q.push_back(t);
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    st(3'b100, 0);
    rd(4'd0, 128'd0, 3'b111, 0);
    rd(4'd10, 128'd0, 3'b111, 1);
    rd_end();

    expect_lat();
    send(K1);
    st(3'b010, 1);
    wait_kv(1);
    tick();
    st(3'b101, 2);
    rd(4'd1, K1_R1, 3'b111, 2);
    rd(4'd10, K1_RA, 3'b111, 3);
    rd(4'd0, K1, 3'b111, 4);
    rd(4'd11, 128'd0, 3'b111, 5);
    rd(4'd15, 128'd0, 3'b111, 6);
    rd_end();

    expect_lat();
    send(K1);
    tick(4);
    KEY_IN = K2;
    KEY_VALID = 1'b1;
    st(3'b010, 3);
    tick();
    KEY_VALID = 1'b0;
    wait_kv(2);
    rd(4'd10, K1_RA, 3'b111, 7);
    rd(4'd0, K1, 3'b111, 8);
    rd_end();

    expect_lat();
    send(K2);
    st(3'b010, 4);
    wait_kv(3);
    rd(4'd10, K2_RA, 3'b111, 9);
    rd(4'd0, K2, 3'b111, 10);
    rd_end();

    send(K1);
    tick(6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    st(3'b100, 5);
    for (int i = 0; i < 11; i++) rd(4'(i), 128'd0, 3'b111, 20 + i);
    rd_end();

    expect_lat();
    send(K1);
    wait_kv(4);
    rd(4'd1, K1_R1, 3'b111, 11);
    rd(4'd10, K1_RA, 3'b111, 12);
    rd_end();

`ifdef KS_ZEROIZE_EN
    tick();
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    st(3'b100, 6);
    for (int i = 0; i < 11; i++) rd(4'(i), 128'd0, 3'b111, 40 + i);
    rd_end();
`endif

    tick(3);
    fin = 1'b1;
    tick(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
